alarm_sequencer: RTL
====================

# alarm_sequencer

Top-level alarm controller that sequences the 4-digit code checker. It gates keypad strobes into the checker and clears partially entered codes on inactivity. It consumes the checker's result code to arm and disarm the system, run the exit and entry delays, and drive the siren. It also enforces a lockout after repeated wrong codes. It sits between the keypad decoder, the code checker, the door/PIR sensor input and the siren/LED drivers.

## Interface
- `EXIT_DELAY`, default 8, cycles from arming code to ARMED.
- `ENTRY_DELAY`, default 6, cycles from sensor trip to ALARM.
- `DIGIT_TIMEOUT`, default 5, idle cycles allowed between digits of a partial code.
- `MAX_FAILS`, default 3, consecutive wrong codes that trigger lockout.
- `LOCKOUT_CYCLES`, default 10, lockout duration.
- `CLK` in 1: system clock. Single clock domain.
- `RST` in 1: synchronous, active-high reset.
- `KB_RECV` in 1: one-cycle key-press strobe, already in the `CLK` domain.
- `KEY_STATUS` in 2: checker result. 0 = KEY_OK, 2 = KEY_ERROR, 3 = NO_KEY; value 1 is treated as NO_KEY.
- `SENSOR` in 1: door/PIR trip, level, already synchronized.
- `KB_EN` out 1: gate for `KB_RECV` into the checker.
- `CHK_CLR` out 1: one-cycle clear of the checker's digit counter.
- `ARMED` out 1: high in ARMED, ENTRY_DLY and ALARM.
- `SIREN` out 1: high only in ALARM.
- `LOCKED` out 1: lockout active.
- `FAIL_CNT` out 2: consecutive wrong-code count.
- `STATE` out 3: state encoding, for debug.

## Operation
- **Main FSM states:** DISARMED, EXIT_DLY, ARMED, ENTRY_DLY, ALARM.
- **Result event:** `KEY_STATUS` is OK or ERROR in this cycle and was NO_KEY in the previous cycle. A held result produces exactly one event.
- **KEY_OK transitions:** DISARMED→EXIT_DLY; EXIT_DLY→DISARMED (cancel); ARMED, ENTRY_DLY and ALARM→DISARMED. KEY_OK clears `FAIL_CNT`.
- **KEY_ERROR:** main state is unchanged and `FAIL_CNT` increments. When it reaches `MAX_FAILS`, `LOCKED` sets, `FAIL_CNT` clears and `CHK_CLR` pulses.
- **Timed transitions:** EXIT_DLY→ARMED after `EXIT_DELAY` cycles. ARMED with `SENSOR`=1 →ENTRY_DLY. ENTRY_DLY→ALARM after `ENTRY_DELAY` cycles.
- **Sensor in other states:** ignored in DISARMED and EXIT_DLY.
- **ALARM:** held until a KEY_OK event.
- **Lockout:** orthogonal to the main FSM. While `LOCKED`=1, `KB_EN`=0 and `KB_RECV` is ignored internally, but the main FSM keeps running, so an entry delay can still expire into ALARM. `LOCKED` clears after `LOCKOUT_CYCLES`.
- **Digit tracking:** a 2-bit digit counter increments on each accepted `KB_RECV` and wraps after the 4th digit.
- **Digit timeout:** if the digit counter is 1–3 and `DIGIT_TIMEOUT` cycles pass with no strobe, `CHK_CLR` pulses and the counter goes to 0. A timeout is not counted as a failure.
- **Counter widths:** `$clog2` of the largest delay parameter + 1. Timers load at state entry and count down to 0.

## Timing
- **Reset values:** DISARMED, `ARMED`=0, `SIREN`=0, `LOCKED`=0, `FAIL_CNT`=0, `KB_EN`=1, `STATE`=0, all timers 0.
- **`CHK_CLR` reset behaviour:** resets to 1 and drops in the first cycle after `RST` deasserts.
- **Registered outputs:** all outputs are registered. A result event sampled at edge N is visible on the outputs after edge N+1 (one-cycle latency).
- **Delay lengths:** the delay is exact. A state entered at edge N with delay D has its timeout transition at edge N+D.
- **Simultaneous events (priority):**
  - KEY_OK beats a sensor trip, EXIT/ENTRY expiry and lockout start.
  - Expiry beats KEY_ERROR; the failure is still counted.
  - `KB_RECV` beats the digit timeout (the timer reloads).
  - Lockout expiry together with a new strobe: the strobe is still ignored that cycle.
- **Reset mid-operation:** all state returns to reset values on the next edge, including ALARM and lockout.

## Structure
- **Shared package `alarm_pkg`:**
  - KEY_STATUS codes: KEY_OK=0, KEY_ERROR=2, NO_KEY=3.
  - Main-state enum: DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4.
- **Sub-module `down_timer`:** loadable down-counter with `load`, `value` and `done`. It is instantiated three times: the delay timer shared by EXIT/ENTRY, the lockout timer and the digit timeout timer.

## Test plan
- **Arm and disarm:** reset, then KEY_OK event → ARMED after exactly 8 cycles. Second KEY_OK → DISARMED 1 cycle later, `ARMED`=0.
- **Intrusion:** ARMED, `SENSOR` pulse → ENTRY_DLY. No code → `SIREN`=1 exactly 6 cycles later. KEY_OK → `SIREN`=0 and DISARMED.
- **Lockout:** three KEY_ERROR events → `FAIL_CNT` goes 1, 2, then `LOCKED`=1, `FAIL_CNT`=0, `KB_EN`=0 and one `CHK_CLR` pulse. `LOCKED` clears 10 cycles later.
- **Digit timeout:** two `KB_RECV` strobes, then 5 idle cycles → a single `CHK_CLR` pulse, `FAIL_CNT` unchanged. A strobe on cycle 4 reloads the timer and gives no pulse.
- **Simultaneous events:** KEY_OK in the same cycle as EXIT_DLY expiry → DISARMED, not ARMED. `SENSOR` together with KEY_OK in ARMED → DISARMED.
- **Mid-alarm reset and held result:** `RST` during ALARM → next cycle `SIREN`=0, DISARMED, `CHK_CLR`=1. `KEY_STATUS` held at ERROR for 5 cycles counts once.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: checker result codes, main-state
// encoding and a small constant helper for sizing timers.
package alarm_pkg;

    localparam logic [1:0] KEY_OK    = 2'd0;
    localparam logic [1:0] KEY_ERROR = 2'd2;
    localparam logic [1:0] NO_KEY    = 2'd3;

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_EXIT_DLY  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ENTRY_DLY = 3'd3,
        ST_ALARM     = 3'd4
    } main_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter. done flags the cycle whose clock edge brings the count
// to zero, so a load of D at edge N produces its expiry at edge N+D.
module down_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: arms/disarms from checker results, runs exit/entry delays,
// drives the siren, locks out after repeated wrong codes and times out partial codes.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int EXIT_DELAY     = 8,
    parameter int ENTRY_DELAY    = 6,
    parameter int DIGIT_TIMEOUT  = 5,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_RECV,
    input  logic [1:0] KEY_STATUS,
    input  logic       SENSOR,
    output logic       KB_EN,
    output logic       CHK_CLR,
    output logic       ARMED,
    output logic       SIREN,
    output logic       LOCKED,
    output logic [1:0] FAIL_CNT,
    output logic [2:0] STATE
);

    localparam int MAX_DLY = max_of(max_of(EXIT_DELAY, ENTRY_DELAY),
                                    max_of(DIGIT_TIMEOUT, LOCKOUT_CYCLES));
    localparam int TW = $clog2(MAX_DLY) + 1;

    main_state_e state_q, state_d;
    logic [1:0]  status_q, status_d, prev_q, prev_d;
    logic        armed_q, armed_d, siren_q, siren_d;
    logic        locked_q, locked_d, kb_en_q, kb_en_d, chk_clr_q, chk_clr_d;
    logic [1:0]  fail_q, fail_d, digit_q, digit_d;

    logic          ok_evt, err_evt, strobe_ok, dly_expired;
    logic          dly_load, dly_done, lock_load, lock_done, dig_load, dig_done;
    logic [TW-1:0] dly_val;

    always_comb begin
        // Code 1 is folded into NO_KEY so it can arm the next edge-detect.
        status_d = (KEY_STATUS == 2'd1) ? NO_KEY : KEY_STATUS;
        prev_d   = status_q;

        ok_evt      = (prev_q == NO_KEY) && (status_q == KEY_OK);
        err_evt     = (prev_q == NO_KEY) && (status_q == KEY_ERROR);
        strobe_ok   = KB_RECV && !locked_q;
        dly_expired = dly_done && ((state_q == ST_EXIT_DLY) || (state_q == ST_ENTRY_DLY));

        state_d = state_q;
        if (ok_evt) begin
            state_d = (state_q == ST_DISARMED) ? ST_EXIT_DLY : ST_DISARMED;
        end else begin
            unique case (state_q)
                ST_EXIT_DLY:  if (dly_expired) state_d = ST_ARMED;
                ST_ARMED:     if (SENSOR) state_d = ST_ENTRY_DLY;
                ST_ENTRY_DLY: if (dly_expired) state_d = ST_ALARM;
                default:      state_d = state_q;
            endcase
        end

        dly_load = (state_d != state_q) &&
                   ((state_d == ST_EXIT_DLY) || (state_d == ST_ENTRY_DLY));
        dly_val  = (state_d == ST_EXIT_DLY) ? TW'(EXIT_DELAY) : TW'(ENTRY_DELAY);

        fail_d    = fail_q;
        locked_d  = locked_q;
        lock_load = 1'b0;
        chk_clr_d = 1'b0;
        digit_d   = digit_q;
        dig_load  = 1'b0;

        if (locked_q && lock_done) begin
            locked_d = 1'b0;
        end

        if (ok_evt) begin
            fail_d = 2'd0;
        end else if (err_evt) begin
            if (int'(fail_q) + 1 >= MAX_FAILS) begin
                fail_d    = 2'd0;
                locked_d  = 1'b1;
                lock_load = 1'b1;
                chk_clr_d = 1'b1;
            end else begin
                fail_d = fail_q + 2'd1;
            end
        end

        // A strobe always wins over the timeout; after the 4th digit no timeout runs.
        if (strobe_ok) begin
            digit_d  = digit_q + 2'd1;
            dig_load = (digit_q != 2'd3);
        end else if ((digit_q != 2'd0) && dig_done) begin
            digit_d   = 2'd0;
            chk_clr_d = 1'b1;
        end
        if (lock_load) begin
            digit_d = 2'd0;
        end

        armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DLY) || (state_d == ST_ALARM);
        siren_d = (state_d == ST_ALARM);
        kb_en_d = !locked_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_DISARMED;
            status_q  <= NO_KEY;
            prev_q    <= NO_KEY;
            armed_q   <= 1'b0;
            siren_q   <= 1'b0;
            locked_q  <= 1'b0;
            kb_en_q   <= 1'b1;
            chk_clr_q <= 1'b1;
            fail_q    <= 2'd0;
            digit_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            siren_q   <= siren_d;
            locked_q  <= locked_d;
            kb_en_q   <= kb_en_d;
            chk_clr_q <= chk_clr_d;
            fail_q    <= fail_d;
            digit_q   <= digit_d;
        end
    end

    down_timer #(.W(TW)) u_dly_timer (
        .clk   (CLK),
        .rst   (RST),
        .load  (dly_load),
        .value (dly_val),
        .done  (dly_done)
    );

    down_timer #(.W(TW)) u_lock_timer (
        .clk   (CLK),
        .rst   (RST),
        .load  (lock_load),
        .value (TW'(LOCKOUT_CYCLES)),
        .done  (lock_done)
    );

    down_timer #(.W(TW)) u_digit_timer (
        .clk   (CLK),
        .rst   (RST),
        .load  (dig_load),
        .value (TW'(DIGIT_TIMEOUT)),
        .done  (dig_done)
    );

    assign KB_EN    = kb_en_q;
    assign CHK_CLR  = chk_clr_q;
    assign ARMED    = armed_q;
    assign SIREN    = siren_q;
    assign LOCKED   = locked_q;
    assign FAIL_CNT = fail_q;
    assign STATE    = state_q;

endmodule
